// File: rtl/xor_chk_pkg.sv
// -----------------------------------------------------------------------------
// xor_chk_pkg
// Shared definitions for the XOR gate response checker:
//   - checker FSM state encoding
//   - full-coverage constant for the four {a,b} input combinations
//   - reference model of the gate and the coverage bit selector
// -----------------------------------------------------------------------------
package xor_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] COV_FULL = 4'b1111;

  // Golden model of the gate under observation.
  function automatic logic expected_xor(input logic a, input logic b);
    expected_xor = a ^ b;
  endfunction

  // One-hot coverage bit for input pair {a,b}: 00->bit0, 01->bit1, 10->bit2, 11->bit3.
  function automatic logic [3:0] cov_bit(input logic a, input logic b);
    cov_bit = 4'b0001 << {a, b};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that holds at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset, clears q
//   clr   - synchronous clear, has priority over inc
//   inc   - count enable
//   q     - registered count value (W bits)
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = {W{1'b1}};

  // Count register: clear wins over increment, increment stops at MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (inc && (q != MAX)) begin
      q <= q + W'(1);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/xor_resp_checker.sv
// -----------------------------------------------------------------------------
// xor_resp_checker
// Samples the inputs (a, b) and output (d) of a two-input XOR gate on each
// qualifying sample_en strobe, compares d against a ^ b, counts vectors and
// mismatches, and reports a pass/fail verdict after NUM_VECTORS vectors.
//
// Optional feature macro: XOR_CHK_COVER_EN
//   defined   - cov_mask port/register exist; pass also needs all four {a,b}
//               combinations to have been seen in the window.
//   undefined - no cov_mask; pass depends only on err_cnt == 0.
//
// Parameters:
//   NUM_VECTORS - vectors per check window (1 .. 2^CNT_W-1)
//   CNT_W       - width of vec_cnt / err_cnt
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   start     in   opens / restarts a check window (wins over sample_en)
//   sample_en in   a/b/d valid this cycle
//   a, b      in   observed gate inputs
//   d         in   observed gate output
//   busy      out  window in progress
//   done      out  window complete, held until next start or reset
//   pass      out  verdict, valid while done
//   mismatch  out  one-cycle pulse after a mismatching sample
//   vec_cnt   out  vectors sampled in the current window
//   err_cnt   out  mismatches in the current window (saturating)
//   cov_mask  out  {a,b} combinations seen (only with XOR_CHK_COVER_EN)
// -----------------------------------------------------------------------------
module xor_resp_checker
  import xor_chk_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sample_en,
  input  logic             a,
  input  logic             b,
  input  logic             d,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt
`ifdef XOR_CHK_COVER_EN
  ,
  output logic [3:0]       cov_mask
`endif
);

  // Count value held by vec_cnt just before the sample that closes the window.
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VECTORS - 1);

  state_t state_r;
  state_t state_s;
  logic   clr_s;
  logic   accept_s;
  logic   to_done_s;
  logic   miss_s;
  logic   pass_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_s   = state_r;
    clr_s     = 1'b0;
    accept_s  = 1'b0;
    to_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          clr_s   = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        // start beats sample_en: the colliding sample is dropped entirely.
        if (start) begin
          clr_s   = 1'b1;
          state_s = RUN;
        end else if (sample_en) begin
          accept_s = 1'b1;
          if (vec_cnt == LAST_VEC) begin
            to_done_s = 1'b1;
            state_s   = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          clr_s   = 1'b1;
          state_s = RUN;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign miss_s = accept_s & (d != expected_xor(a, b));

  // vec_cnt only increments on accepted samples and the FSM leaves RUN when
  // it reaches NUM_VECTORS, so it cannot exceed the window length.
  sat_counter #(.W(CNT_W)) u_vec_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .inc   (accept_s),
    .q     (vec_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_s),
    .inc   (miss_s),
    .q     (err_cnt)
  );

`ifdef XOR_CHK_COVER_EN
  logic [3:0] cov_next_s;

  assign cov_next_s = cov_mask | cov_bit(a, b);

  // Coverage register: cleared on window open, accumulates accepted pairs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cov_mask <= 4'b0000;
    end else if (clr_s) begin
      cov_mask <= 4'b0000;
    end else if (accept_s) begin
      cov_mask <= cov_next_s;
    end else begin
      cov_mask <= cov_mask;
    end
  end

  // Verdict looks at the counters as they will be after the closing sample.
  assign pass_s = (err_cnt == {CNT_W{1'b0}}) & ~miss_s & (cov_next_s == COV_FULL);
`else
  assign pass_s = (err_cnt == {CNT_W{1'b0}}) & ~miss_s;
`endif

  // Status and verdict registers, aligned with the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      busy     <= (state_s == RUN);
      done     <= (state_s == DONE);
      mismatch <= miss_s;
      if (clr_s) begin
        pass <= 1'b0;
      end else if (to_done_s) begin
        pass <= pass_s;
      end else begin
        pass <= pass;
      end
    end
  end

endmodule

// File: tb/tb_xor_resp_checker.sv
// -----------------------------------------------------------------------------
// tb_xor_resp_checker
// Directed self-checking bench for xor_resp_checker. Works with and without
// XOR_CHK_COVER_EN; coverage expectations follow the macro.
// u_dut  : default parameters (NUM_VECTORS=4, CNT_W=8)
// u_dut2 : NUM_VECTORS=3, CNT_W=2 for saturation / small-window behaviour
// u_cnt  : stand-alone 2-bit sat_counter for wrap-vs-hold behaviour
// -----------------------------------------------------------------------------
module tb_xor_resp_checker;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sample_en;
  logic       a;
  logic       b;
  logic       d;

  logic       busy, done, pass, mismatch;
  logic [7:0] vec_cnt, err_cnt;
  logic       busy2, done2, pass2, mismatch2;
  logic [1:0] vec_cnt2, err_cnt2;
`ifdef XOR_CHK_COVER_EN
  logic [3:0] cov_mask, cov_mask2;
`endif

  logic       sc_clr, sc_inc;
  logic [1:0] sc_q;

  int checks;
  int errors;

  xor_resp_checker #(.NUM_VECTORS(4), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .d(d),
    .busy(busy), .done(done), .pass(pass), .mismatch(mismatch),
    .vec_cnt(vec_cnt), .err_cnt(err_cnt)
`ifdef XOR_CHK_COVER_EN
    , .cov_mask(cov_mask)
`endif
  );

  xor_resp_checker #(.NUM_VECTORS(3), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start), .sample_en(sample_en),
    .a(a), .b(b), .d(d),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch(mismatch2),
    .vec_cnt(vec_cnt2), .err_cnt(err_cnt2)
`ifdef XOR_CHK_COVER_EN
    , .cov_mask(cov_mask2)
`endif
  );

  sat_counter #(.W(2)) u_cnt (
    .clk(clk), .reset(reset), .clr(sc_clr), .inc(sc_inc), .q(sc_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_sample(input logic va, input logic vb, input logic vd);
    a = va; b = vb; d = vd; sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; sample_en = 1'b0; a = 1'b0; b = 1'b0; d = 1'b0;
    sc_clr = 1'b0; sc_inc = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, pass, mismatch} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, pass, mismatch});
    end
    checks++;
    if (vec_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_cnts: got vec=%0d err=%0d want 0 0", vec_cnt, err_cnt);
    end
`ifdef XOR_CHK_COVER_EN
    checks++;
    if (cov_mask !== 4'b0000) begin
      errors++; $display("FAIL reset_cov: got %b want 0000", cov_mask);
    end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_clean_window();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || vec_cnt !== 8'd0) begin
      errors++; $display("FAIL clean_start: got busy=%b done=%b vec=%0d want 1 0 0", busy, done, vec_cnt);
    end
    drive_sample(1'b0, 1'b0, 1'b0);
    checks++;
    if (vec_cnt !== 8'd1 || mismatch !== 1'b0) begin
      errors++; $display("FAIL clean_first: got vec=%0d mis=%b want 1 0", vec_cnt, mismatch);
    end
    drive_sample(1'b1, 1'b0, 1'b1);
    drive_sample(1'b0, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || vec_cnt !== 8'd3) begin
      errors++; $display("FAIL clean_mid: got busy=%b done=%b vec=%0d want 1 0 3", busy, done, vec_cnt);
    end
    drive_sample(1'b1, 1'b1, 1'b0);
    checks++;
    if ({busy, done, pass, mismatch} !== 4'b0110) begin
      errors++; $display("FAIL clean_verdict: got busy,done,pass,mis=%b want 0110", {busy, done, pass, mismatch});
    end
    checks++;
    if (vec_cnt !== 8'd4 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL clean_cnts: got vec=%0d err=%0d want 4 0", vec_cnt, err_cnt);
    end
`ifdef XOR_CHK_COVER_EN
    checks++;
    if (cov_mask !== 4'b1111) begin
      errors++; $display("FAIL clean_cov: got %b want 1111", cov_mask);
    end
`endif
    // Samples in DONE are ignored and done/pass are held.
    drive_sample(1'b1, 1'b1, 1'b1);
    tick();
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || vec_cnt !== 8'd4 || err_cnt !== 8'd0 || mismatch !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done=%b pass=%b vec=%0d err=%0d mis=%b want 1 1 4 0 0",
                         done, pass, vec_cnt, err_cnt, mismatch);
    end
  endtask

  task automatic test_faulty_gate();
    // Restart straight from DONE.
    pulse_start();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || vec_cnt !== 8'd0) begin
      errors++; $display("FAIL restart_done: got busy=%b done=%b pass=%b vec=%0d want 1 0 0 0",
                         busy, done, pass, vec_cnt);
    end
    // d = a | b : differs from XOR only on 11.
    drive_sample(1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 1'b0, 1'b1);
    drive_sample(1'b0, 1'b1, 1'b1);
    checks++;
    if (mismatch !== 1'b0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL fault_pre: got mis=%b err=%0d want 0 0", mismatch, err_cnt);
    end
    drive_sample(1'b1, 1'b1, 1'b1);
    checks++;
    if (mismatch !== 1'b1 || err_cnt !== 8'd1) begin
      errors++; $display("FAIL fault_hit: got mis=%b err=%0d want 1 1", mismatch, err_cnt);
    end
    checks++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      errors++; $display("FAIL fault_verdict: got done=%b pass=%b want 1 0", done, pass);
    end
    tick();
    checks++;
    if (mismatch !== 1'b0) begin
      errors++; $display("FAIL fault_pulse_len: got mis=%b want 0", mismatch);
    end
  endtask

  task automatic test_cov_hole();
    pulse_start();
    for (int i = 0; i < 4; i++) drive_sample(1'b0, 1'b0, 1'b0);
    checks++;
    if (done !== 1'b1 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL hole_done: got done=%b err=%0d want 1 0", done, err_cnt);
    end
`ifdef XOR_CHK_COVER_EN
    checks++;
    if (cov_mask !== 4'b0001 || pass !== 1'b0) begin
      errors++; $display("FAIL hole_cov: got cov=%b pass=%b want 0001 0", cov_mask, pass);
    end
`else
    checks++;
    if (pass !== 1'b1) begin
      errors++; $display("FAIL hole_pass: got %b want 1", pass);
    end
`endif
  endtask

  task automatic test_restart_collision();
    pulse_start();
    drive_sample(1'b0, 1'b1, 1'b1);
    drive_sample(1'b1, 1'b0, 1'b1);
    checks++;
    if (vec_cnt !== 8'd2) begin
      errors++; $display("FAIL coll_pre: got vec=%0d want 2", vec_cnt);
    end
    // Mismatching sample lands together with start.
    start = 1'b1;
    drive_sample(1'b1, 1'b1, 1'b1);
    start = 1'b0;
    checks++;
    if (vec_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL coll_cnts: got vec=%0d err=%0d want 0 0", vec_cnt, err_cnt);
    end
    checks++;
    if (mismatch !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL coll_flags: got mis=%b busy=%b done=%b want 0 1 0", mismatch, busy, done);
    end
  endtask

  task automatic test_mid_reset();
    pulse_start();
    drive_sample(1'b0, 1'b0, 1'b0);
    drive_sample(1'b1, 1'b0, 1'b1);
    drive_sample(1'b1, 1'b1, 1'b1);
    checks++;
    if (busy !== 1'b1 || vec_cnt !== 8'd3 || mismatch !== 1'b1) begin
      errors++; $display("FAIL mrst_pre: got busy=%b vec=%0d mis=%b want 1 3 1", busy, vec_cnt, mismatch);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, pass, mismatch} !== 4'b0000 || vec_cnt !== 8'd0 || err_cnt !== 8'd0) begin
      errors++; $display("FAIL mrst_async: got flags=%b vec=%0d err=%0d want 0000 0 0",
                         {busy, done, pass, mismatch}, vec_cnt, err_cnt);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive_sample(1'b1, 1'b0, 1'b1);
    checks++;
    if (vec_cnt !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL mrst_idle: got vec=%0d busy=%b done=%b want 0 0 0", vec_cnt, busy, done);
    end
  endtask

  task automatic test_saturation();
    pulse_start();
    drive_sample(1'b0, 1'b0, 1'b1);
    drive_sample(1'b0, 1'b1, 1'b0);
    checks++;
    if (done2 !== 1'b0 || err_cnt2 !== 2'd2 || vec_cnt2 !== 2'd2) begin
      errors++; $display("FAIL sat_mid: got done=%b err=%0d vec=%0d want 0 2 2", done2, err_cnt2, vec_cnt2);
    end
    drive_sample(1'b1, 1'b1, 1'b1);
    checks++;
    if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b0 || mismatch2 !== 1'b1) begin
      errors++; $display("FAIL sat_done: got done=%b busy=%b pass=%b mis=%b want 1 0 0 1",
                         done2, busy2, pass2, mismatch2);
    end
    checks++;
    if (err_cnt2 !== 2'd3 || vec_cnt2 !== 2'd3) begin
      errors++; $display("FAIL sat_cnts: got err=%0d vec=%0d want 3 3", err_cnt2, vec_cnt2);
    end
    drive_sample(1'b1, 1'b0, 1'b0);
    drive_sample(1'b0, 1'b0, 1'b1);
    checks++;
    if (err_cnt2 !== 2'd3 || vec_cnt2 !== 2'd3 || done2 !== 1'b1 || mismatch2 !== 1'b0) begin
      errors++; $display("FAIL sat_after: got err=%0d vec=%0d done=%b mis=%b want 3 3 1 0",
                         err_cnt2, vec_cnt2, done2, mismatch2);
    end
    // Bare counter: five increments on a 2-bit counter must stop at 3.
    sc_clr = 1'b1; tick(); sc_clr = 1'b0;
    sc_inc = 1'b1; tick(); tick();
    checks++;
    if (sc_q !== 2'd2) begin
      errors++; $display("FAIL cnt_two: got %0d want 2", sc_q);
    end
    tick(); tick(); tick();
    sc_inc = 1'b0;
    checks++;
    if (sc_q !== 2'd3) begin
      errors++; $display("FAIL cnt_sat: got %0d want 3", sc_q);
    end
    sc_clr = 1'b1; sc_inc = 1'b1; tick(); sc_clr = 1'b0; sc_inc = 1'b0;
    checks++;
    if (sc_q !== 2'd0) begin
      errors++; $display("FAIL cnt_clr: got %0d want 0", sc_q);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_clean_window();
    test_faulty_gate();
    test_cov_hole();
    test_restart_collision();
    test_mid_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
